uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with configurable framing and a small receive FIFO
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_W   = 14
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [3:0]                   data_size,
    input  logic [PERIOD_W-1:0]          bit_period,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop,
    input  logic                         serial_in,
    input  logic                         data_read,
    output logic [7:0]                   rx_data,
    output logic                         data_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         parity_error,
    output logic                         framing_error,
    output logic                         overrun_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        STORE
    } state_t;

    // line synchronizer and edge history
    logic          sync1_q, sync2_q, prev_q;
    logic [2:0]    flush_q;

    // receiver state
    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          data_q, data_d;
    logic [3:0]          size_q, size_d;
    logic [1:0]          par_q, par_d;
    logic                two_q, two_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic                pe_q, pe_d;
    logic                fe_q, fe_d;

    // fifo state
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q;

    logic                fall;
    logic                sample;
    logic [PERIOD_W-1:0] target;
    logic                store;
    logic                pop, push, drop, full, empty;
    logic [9:0]          head;

    // Two-flop synchronizer; flush_q hides the reset value of the flops from the
    // edge detector so a line held low through reset never looks like a start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            flush_q <= 3'b000;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            flush_q <= {flush_q[1:0], 1'b1};
        end
    end

    assign fall   = (flush_q == 3'b111) && prev_q && !sync2_q;
    assign target = (state_q == START) ? (per_q >> 1) : per_q;
    assign sample = (cnt_q == target);

    // Receiver state and frame registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            size_q  <= 4'd8;
            par_q   <= '0;
            two_q   <= 1'b0;
            per_q   <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            size_q  <= size_d;
            par_q   <= par_d;
            two_q   <= two_d;
            per_q   <= per_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
        end
    end

    // Frame FSM: cnt_q counts cycles since the last sample point (or start edge)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        size_d  = size_q;
        par_d   = par_q;
        two_d   = two_q;
        per_d   = per_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        store   = 1'b0;

        if (state_q != IDLE && state_q != STORE) begin
            cnt_d = sample ? PERIOD_W'(1) : cnt_q + PERIOD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = PERIOD_W'(1);
                    bit_d   = '0;
                    data_d  = '0;
                    pe_d    = 1'b0;
                    fe_d    = 1'b0;
                    size_d  = (data_size >= 4'd5 && data_size <= 4'd8) ? data_size : 4'd8;
                    par_d   = parity_mode;
                    two_d   = two_stop;
                    per_d   = bit_period;
                end
            end
            START: begin
                if (sample) begin
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    data_d[bit_q] = sync2_q;
                    if ({1'b0, bit_q} == size_q - 4'd1) begin
                        state_d = (par_q == 2'b01 || par_q == 2'b10) ? PARITY : STOP1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    pe_d    = (par_q == 2'b01) ? (^data_q ^ sync2_q) : ~(^data_q ^ sync2_q);
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (sample) begin
                    fe_d    = ~sync2_q;
                    state_d = two_q ? STOP2 : STORE;
                end
            end
            STOP2: begin
                if (sample) begin
                    fe_d    = fe_q | ~sync2_q;
                    state_d = STORE;
                end
            end
            STORE: begin
                store   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = data_read && !empty;
    assign push  = store && (!full || pop);
    assign drop  = store && full && !pop;

    // Occupancy follows the push/pop pair; a simultaneous pair leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO pointers, count and sticky overrun flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end else if (pop) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Entry storage; contents are masked at the outputs while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {data_q, pe_q, fe_q};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rx_data       = empty ? 8'h00 : head[9:2];
    assign parity_error  = empty ? 1'b0 : head[1];
    assign framing_error = empty ? 1'b0 : head[0];
    assign data_ready    = !empty;
    assign fifo_count    = count_q;
    assign overrun_error = ovr_q;

endmodule
